// File: rtl/commit_trace_fifo.sv
// Pairs each retired instruction with the memory access reported one cycle later,
// tags it with a sequence number and buffers it for the reference-model checker.
module commit_trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       commit_valid,
    input  logic [31:0]                commit_pc,
    input  logic [31:0]                commit_inst,
    input  logic [4:0]                 commit_rd_addr,
    input  logic [31:0]                commit_rd_wdata,
    input  logic                       mem_valid,
    input  logic                       mem_is_write,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_data,
    input  logic [6:0]                 mem_width,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [4:0]                 out_rd_addr,
    output logic [31:0]                out_rd_wdata,
    output logic                       out_mem_valid,
    output logic                       out_mem_is_write,
    output logic [31:0]                out_mem_addr,
    output logic [31:0]                out_mem_data,
    output logic [6:0]                 out_mem_width,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = SEQ_W + 32 + 32 + 5 + 32 + 1 + 1 + 32 + 32 + 7;

    logic             r_stage_v;
    logic [SEQ_W-1:0] r_stage_seq;
    logic [31:0]      r_stage_pc;
    logic [31:0]      r_stage_inst;
    logic [4:0]       r_stage_rd_addr;
    logic [31:0]      r_stage_rd_wdata;
    logic [SEQ_W-1:0] r_seq;

    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic             w_out_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_head;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage_v        <= 1'b0;
            r_stage_seq      <= '0;
            r_stage_pc       <= '0;
            r_stage_inst     <= '0;
            r_stage_rd_addr  <= '0;
            r_stage_rd_wdata <= '0;
            r_seq            <= '0;
        end else begin
            r_stage_v <= commit_valid;
            if (commit_valid) begin
                r_stage_seq      <= r_seq;
                r_stage_pc       <= commit_pc;
                r_stage_inst     <= commit_inst;
                r_stage_rd_addr  <= commit_rd_addr;
                r_stage_rd_wdata <= commit_rd_wdata;
                r_seq            <= r_seq + SEQ_W'(1);
            end
        end
    end

    // Mem fields are zeroed when no access was reported so records compare cleanly.
    assign w_rec = {r_stage_seq, r_stage_pc, r_stage_inst, r_stage_rd_addr, r_stage_rd_wdata,
                    mem_valid,
                    mem_valid & mem_is_write,
                    mem_valid ? mem_addr  : 32'd0,
                    mem_valid ? mem_data  : 32'd0,
                    mem_valid ? mem_width : 7'd0};

    assign w_out_valid = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_pop       = w_out_valid & out_ready;
    assign w_push      = r_stage_v & (~w_full | w_pop);
    assign w_drop      = r_stage_v & w_full & ~w_pop;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
                end
            end
        end
    end

    // Stale storage is masked so every output reads zero while the FIFO is empty.
    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

    assign {out_seq, out_pc, out_inst, out_rd_addr, out_rd_wdata,
            out_mem_valid, out_mem_is_write, out_mem_addr, out_mem_data, out_mem_width} = w_head;

    assign out_valid = w_out_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
endmodule
